macro_bist_sequencer: RTL and testbench
=======================================

// Module: macro_bist_sequencer
// PURPOSE
//  Stimulus and response engine that exercises a hardened GDS macro from inside a TT user design.
//  - Drives an 8-bit pseudo-random vector stream (LFSR) into the macro's input bus.
//  - Compacts the macro's 8-bit response stream into a 32-bit MISR signature.
//  - Exposes the signature byte-wise for readout on uo_out.
//  - Sits between the TT pin wrapper (start/seed from ui_in, result to uo_out) and the macro instance.
// PARAMETERS
//  VECTORS  256  vectors per run, 1..65535
//  LATENCY  2    macro input-to-response latency in clk cycles, 1..8
// PORTS
//  clk       in   1   single clock
//  rst_n     in   1   reset, synchronous, active-low
//  ena       in   1   0 = freeze all state (hold), 1 = run
//  start     in   1   level-sampled run request
//  seed      in   8   LFSR seed, captured at run start
//  mac_stim  out  8   stimulus to macro
//  mac_resp  in   8   response from macro
//  busy      out  1   high in RUN and DRAIN
//  done      out  1   high in DONE
//  sig_sel   in   2   signature byte select, 0 = bits[7:0] .. 3 = bits[31:24]
//  sig_byte  out  8   selected MISR byte (combinational mux of the registered MISR)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//  - state=IDLE; lfsr, misr, vector count and valid pipe cleared.
//  - mac_stim=0, busy=0, done=0, sig_byte=0.
//  ena=0: no register changes; outputs hold.
//  FSM:
//  - IDLE->RUN when start=1. On that edge: lfsr<=seed (seed 0 is replaced by 8'h01), misr<=0, count<=0.
//  - RUN: mac_stim=lfsr. Each cycle lfsr<={lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]} and count++.
//    After VECTORS cycles in RUN, go to DRAIN.
//  - DRAIN: mac_stim=0. Lasts exactly LATENCY cycles, then DONE.
//  - DONE: done=1, misr held. DONE->IDLE when start=0. start held high does not retrigger.
//  - start during RUN or DRAIN is ignored.
//  - mac_stim=0 in every state other than RUN.
//  Capture:
//  - A LATENCY-deep valid shift pipe is fed 1 in each RUN cycle.
//  - When the pipe output is 1, at that edge:
//    misr <= {misr[30:0],1'b0} ^ (misr[31] ? 32'h04C11DB7 : 0) ^ {24'b0, mac_resp}.
//  - The vector driven in cycle t is therefore captured at the edge ending cycle t+LATENCY.
//  - Exactly VECTORS captures per run. The last capture occurs on the DRAIN->DONE edge.
//  Cycle counts:
//  - busy is high for exactly VECTORS+LATENCY cycles.
//  - done rises on the cycle after busy falls.
//  Boundaries:
//  - VECTORS=1 is legal.
//  - count wraps only at VECTORS; the 16-bit counter never overflows.
//  - Reset during RUN or DRAIN aborts immediately; the signature is discarded.
//  - All widths are fixed; no arithmetic beyond the counter increment.
// STRUCTURE
//  - Package macro_bist_pkg holds: state typedef (IDLE, RUN, DRAIN, DONE), LFSR tap constant,
//    MISR_POLY=32'h04C11DB7, reset/seed fallback constant 8'h01.
//  - One sub-module, macro_bist_misr (clk, rst_n, clr, en, din[7:0], sig[31:0]).
//  - FSM, LFSR, counter, valid pipe and readout mux stay in the top module.
// TESTING
//  Loopback model: mac_resp = mac_stim delayed LATENCY cycles.
//  1. VECTORS=1, LATENCY=1, seed=8'h01, start pulse
//     -> mac_stim=8'h01 for 1 cycle, busy 2 cycles, done=1, signature 32'h00000001.
//  2. VECTORS=2, LATENCY=1, seed=8'h01
//     -> stim 8'h01 then 8'h02, signature 32'h00000000, sig_sel=0..3 all read 8'h00.
//  3. seed=8'h00 -> first stim is 8'h01, same result as scenario 1.
//  4. VECTORS=256, LATENCY=2, seed=8'hA5; rst_n=0 on cycle 100 of RUN
//     -> next cycle: IDLE, busy=0, mac_stim=0, sig_byte=0. A rerun matches the uninterrupted signature.
//  5. ena=0 for 5 cycles mid-RUN -> mac_stim and count frozen, busy stays high for 5 extra cycles,
//     signature identical to the run without the stall.
//  6. start held high through DONE -> done stays 1, no second run.
//     start=0 -> IDLE. start=1 again -> new run with misr cleared.

Source files
------------

// File: rtl/macro_bist_pkg.sv
// Shared types and constants for the macro BIST sequencer.
// State encoding, LFSR taps, MISR polynomial and seed fallback.
package macro_bist_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

  // Feedback taps on bits 7,5,4,3.
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [7:0]  SEED_FALLBACK = 8'h01;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] v
  );
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/macro_bist_misr.sv
// 32-bit MISR compacting an 8-bit response stream.
// Ports: clk, rst_n (sync, low), clr, en, din[7:0], sig[31:0].
module macro_bist_misr
  import macro_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] sig
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[30:0], 1'b0}
            ^ (sig_q[31] ? MISR_POLY : 32'h0)
            ^ {24'h0, din};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/macro_bist_sequencer.sv
// LFSR stimulus / MISR response engine for a hardened macro.
// Ports: clk, rst_n, ena, start, seed, mac_stim/mac_resp, busy, done, sig_sel, sig_byte.
module macro_bist_sequencer
  import macro_bist_pkg::*;
#(
  parameter int VECTORS = 256,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] seed,
  output logic [7:0] mac_stim,
  input  logic [7:0] mac_resp,
  output logic       busy,
  output logic       done,
  input  logic [1:0] sig_sel,
  output logic [7:0] sig_byte
);

  localparam logic [15:0] LAST_VEC = 16'(VECTORS - 1);
  localparam logic [15:0] LAST_DRN = 16'(LATENCY - 1);

  state_t state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [LATENCY-1:0] vpipe_q, vpipe_d;

  logic misr_clr;
  logic misr_en;
  logic [31:0] misr_sig;

  logic in_idle, in_run, in_drain, in_done;

  assign in_idle  = (state_q == IDLE);
  assign in_run   = (state_q == RUN);
  assign in_drain = (state_q == DRAIN);
  assign in_done  = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    vpipe_d  = vpipe_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    if (ena) begin
      // Pipe tail marks the cycle whose response is now valid.
      vpipe_d    = vpipe_q << 1;
      vpipe_d[0] = in_run;
      misr_en    = vpipe_q[LATENCY-1];
      unique case (1'b1)
        in_idle: begin
          if (start) begin
            state_d  = RUN;
            lfsr_d   = (seed == 8'h00) ? SEED_FALLBACK : seed;
            cnt_d    = '0;
            misr_clr = 1'b1;
          end
        end
        in_run: begin
          lfsr_d = lfsr_next(lfsr_q);
          if (cnt_q == LAST_VEC) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        in_drain: begin
          // Counter reused to time the drain window.
          if (cnt_q == LAST_DRN) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        in_done: begin
          if (!start) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      vpipe_q <= vpipe_d;
    end
  end

  macro_bist_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (mac_resp),
    .sig   (misr_sig)
  );

  assign mac_stim = in_run ? lfsr_q : 8'h00;
  assign busy     = in_run | in_drain;
  assign done     = in_done;

  always_comb begin
    sig_byte = 8'h00;
    case (sig_sel)
      2'd0: sig_byte = misr_sig[7:0];
      2'd1: sig_byte = misr_sig[15:8];
      2'd2: sig_byte = misr_sig[23:16];
      2'd3: sig_byte = misr_sig[31:24];
      default: sig_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_macro_bist_sequencer.sv
// Bench for macro_bist_sequencer with three parameter sets
// and an ena-gated loopback standing in for the macro.
module tb_macro_bist_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] seed_in;
  logic [1:0] sig_sel;

  logic [7:0] stim_a, stim_b, stim_c;
  logic [7:0] resp_a, resp_b, resp_c, dly_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] sb_a, sb_b, sb_c;

  int checks = 0;
  int failures = 0;

  macro_bist_sequencer #(.VECTORS(1), .LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .seed(seed_in), .mac_stim(stim_a), .mac_resp(resp_a),
    .busy(busy_a), .done(done_a), .sig_sel(sig_sel), .sig_byte(sb_a)
  );

  macro_bist_sequencer #(.VECTORS(2), .LATENCY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .seed(seed_in), .mac_stim(stim_b), .mac_resp(resp_b),
    .busy(busy_b), .done(done_b), .sig_sel(sig_sel), .sig_byte(sb_b)
  );

  macro_bist_sequencer #(.VECTORS(256), .LATENCY(2)) u_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .seed(seed_in), .mac_stim(stim_c), .mac_resp(resp_c),
    .busy(busy_c), .done(done_c), .sig_sel(sig_sel), .sig_byte(sb_c)
  );

  // Macro model: response is the stimulus delayed LATENCY enabled cycles.
  always @(posedge clk) begin
    if (ena) begin
      resp_a <= stim_a;
      resp_b <= stim_b;
      dly_c  <= stim_c;
      resp_c <= dly_c;
    end
  end

  int dsel;
  logic [7:0] m_stim, m_sb;
  logic       m_busy, m_done;

  always_comb begin
    m_stim = stim_c; m_busy = busy_c; m_done = done_c; m_sb = sb_c;
    if (dsel == 0) begin
      m_stim = stim_a; m_busy = busy_a; m_done = done_a; m_sb = sb_a;
    end else if (dsel == 1) begin
      m_stim = stim_b; m_busy = busy_b; m_done = done_b; m_sb = sb_b;
    end
  end

  logic [7:0] exp_q[$];

  function automatic logic [7:0] m_lfsr(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] m, input logic [7:0] d);
    logic [31:0] r;
    r = {m[30:0], 1'b0} ^ {24'h0, d};
    if (m[31]) r = r ^ 32'h04C11DB7;
    return r;
  endfunction

  function automatic logic [31:0] model_sig(input logic [7:0] sd, input int n);
    logic [7:0]  v;
    logic [31:0] m;
    v = (sd == 8'h00) ? 8'h01 : sd;
    m = 32'h0;
    for (int i = 0; i < n; i++) begin
      m = m_misr(m, v);
      v = m_lfsr(v);
    end
    return m;
  endfunction

  task automatic reset_all();
    rst_n = 1'b0;
    start = 1'b0;
    ena   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_sig(output logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      sig_sel = 2'(i);
      #1;
      w[8*i +: 8] = m_sb;
    end
    sig_sel = 2'd0;
  endtask

  // Launch a run on the selected instance; check stimulus, busy length, done timing.
  task automatic run_dut(input int d, input logic [7:0] sd, input int nvec,
                         input int lat, input int stall_at, input bit hold,
                         output logic [31:0] sig);
    logic [7:0] v, got, hv;
    int cyc, busy_cnt, pops, extra;
    logic prev_busy;
    bit stalled;
    dsel = d;
    exp_q.delete();
    v = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < nvec; i++) begin
      exp_q.push_back(v);
      v = m_lfsr(v);
    end
    seed_in = sd;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    cyc = 0; busy_cnt = 0; pops = 0; prev_busy = 1'b0; stalled = 0;
    extra = (stall_at > 0) ? 5 : 0;
    while (!m_done && cyc < 2000) begin
      if (m_busy) busy_cnt++;
      if (m_stim !== 8'h00) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stim_extra dut=%0d got=%h required=none", d, m_stim);
        end else begin
          got = exp_q.pop_front();
          if (m_stim !== got) begin
            failures++;
            $display("FAIL stim dut=%0d idx=%0d got=%h required=%h", d, pops, m_stim, got);
          end
        end
        pops++;
        if (stall_at > 0 && pops == stall_at && !stalled) begin
          stalled = 1;
          hv = m_stim;
          ena = 1'b0;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (m_busy) busy_cnt++;
            checks++;
            if (m_stim !== hv) begin
              failures++;
              $display("FAIL stall_hold k=%0d got=%h required=%h", k, m_stim, hv);
            end
          end
          ena = 1'b1;
        end
      end
      prev_busy = m_busy;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 2000) begin
      failures++;
      $display("FAIL run_timeout dut=%0d got=no_done required=done", d);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL stim_missing dut=%0d got=%0d_left required=0", d, exp_q.size());
    end
    checks++;
    if (busy_cnt != nvec + lat + extra) begin
      failures++;
      $display("FAIL busy_len dut=%0d got=%0d required=%0d", d, busy_cnt, nvec + lat + extra);
    end
    checks++;
    if (!(prev_busy === 1'b1 && m_busy === 1'b0)) begin
      failures++;
      $display("FAIL done_edge dut=%0d got=prev%b_now%b required=prev1_now0", d, prev_busy, m_busy);
    end
    read_sig(sig);
  endtask

  task automatic test_reset();
    logic [31:0] w;
    seed_in = 8'h5A;
    sig_sel = 2'd0;
    reset_all();
    for (int d = 0; d < 3; d++) begin
      dsel = d;
      #1;
      checks++;
      if (m_busy !== 1'b0 || m_done !== 1'b0 || m_stim !== 8'h00) begin
        failures++;
        $display("FAIL reset_out dut=%0d got=b%b_d%b_s%h required=b0_d0_s00", d, m_busy, m_done, m_stim);
      end
      read_sig(w);
      checks++;
      if (w !== 32'h0) begin
        failures++;
        $display("FAIL reset_sig dut=%0d got=%h required=00000000", d, w);
      end
    end
    // ena low: a start request must not be taken.
    dsel = 2;
    ena = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (m_busy !== 1'b0 || m_stim !== 8'h00) begin
      failures++;
      $display("FAIL ena_freeze got=b%b_s%h required=b0_s00", m_busy, m_stim);
    end
    start = 1'b0;
    ena = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_vector();
    logic [31:0] s;
    reset_all();
    run_dut(0, 8'h01, 1, 1, 0, 0, s);
    checks++;
    if (s !== 32'h00000001) begin
      failures++;
      $display("FAIL sig_v1 got=%h required=00000001", s);
    end
  endtask

  task automatic test_two_vectors();
    logic [31:0] s;
    reset_all();
    run_dut(1, 8'h01, 2, 1, 0, 0, s);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s[8*i +: 8] !== 8'h00) begin
        failures++;
        $display("FAIL sig_v2_byte%0d got=%h required=00", i, s[8*i +: 8]);
      end
    end
  endtask

  task automatic test_seed_zero();
    logic [31:0] s;
    reset_all();
    run_dut(0, 8'h00, 1, 1, 0, 0, s);
    checks++;
    if (s !== 32'h00000001) begin
      failures++;
      $display("FAIL sig_seed0 got=%h required=00000001", s);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] s, w;
    int n;
    reset_all();
    dsel = 2;
    seed_in = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      n++;
    end
    sig_sel = 2'd1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (m_busy !== 1'b0 || m_stim !== 8'h00 || m_sb !== 8'h00 || m_done !== 1'b0) begin
      failures++;
      $display("FAIL abort got=b%b_s%h_sb%h_d%b required=b0_s00_sb00_d0", m_busy, m_stim, m_sb, m_done);
    end
    @(negedge clk);
    read_sig(w);
    checks++;
    if (w !== 32'h0) begin
      failures++;
      $display("FAIL abort_sig got=%h required=00000000", w);
    end
    run_dut(2, 8'hA5, 256, 2, 0, 0, s);
    checks++;
    if (s !== model_sig(8'hA5, 256)) begin
      failures++;
      $display("FAIL rerun_sig got=%h required=%h", s, model_sig(8'hA5, 256));
    end
  endtask

  task automatic test_stall();
    logic [31:0] s;
    reset_all();
    run_dut(2, 8'hA5, 256, 2, 100, 0, s);
    checks++;
    if (s !== model_sig(8'hA5, 256)) begin
      failures++;
      $display("FAIL stall_sig got=%h required=%h", s, model_sig(8'hA5, 256));
    end
  endtask

  task automatic test_hold_start();
    logic [31:0] s;
    reset_all();
    run_dut(2, 8'h3C, 256, 2, 0, 1, s);
    checks++;
    if (s !== model_sig(8'h3C, 256)) begin
      failures++;
      $display("FAIL hold_sig got=%h required=%h", s, model_sig(8'h3C, 256));
    end
    repeat (10) @(negedge clk);
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_stim !== 8'h00) begin
      failures++;
      $display("FAIL hold_retrigger got=d%b_b%b_s%h required=d1_b0_s00", m_done, m_busy, m_stim);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      failures++;
      $display("FAIL to_idle got=d%b_b%b required=d0_b0", m_done, m_busy);
    end
    run_dut(2, 8'h81, 256, 2, 0, 0, s);
    checks++;
    if (s !== model_sig(8'h81, 256)) begin
      failures++;
      $display("FAIL second_run_sig got=%h required=%h", s, model_sig(8'h81, 256));
    end
  endtask

  initial begin
    dsel = 2;
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    seed_in = 8'h00;
    sig_sel = 2'd0;
    test_reset();
    test_single_vector();
    test_two_vectors();
    test_seed_zero();
    test_reset_abort();
    test_stall();
    test_hold_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
